// File: rtl/decode_queue_pkg.sv
// Shared types, constants and the next-pc helper used by the decode queue
// and by the decode stage.
package decode_queue_pkg;

  localparam logic [31:0] nop_instr = 32'h00000013;
  localparam int          DQ_XLEN   = 32;

  typedef struct packed {
    logic [DQ_XLEN-1:0] pc;
    logic [31:0]        instr;
  } decode_queue_entry_type;

  typedef struct packed {
    logic               f_valid;
    logic [DQ_XLEN-1:0] f_pc;
    logic [31:0]        f_instr;
    logic               clear;
  } decode_queue_in_type;

  typedef struct packed {
    logic               f_ready;
    logic               d_valid;
    logic [DQ_XLEN-1:0] d_pc;
    logic [31:0]        d_instr;
    logic [DQ_XLEN-1:0] d_npc;
    logic [2:0]         count;
    logic               empty;
    logic               full;
    logic               almost_full;
  } decode_queue_out_type;

  // Computed at 64 bits; callers truncate to their pc width, which keeps
  // the result correct modulo 2^XLEN for any XLEN up to 64.
  function automatic logic [63:0] npc_calc(input logic [63:0] pc, input logic [31:0] instr);
    return pc + ((instr[1:0] == 2'b11) ? 64'd4 : 64'd2);
  endfunction

endpackage

// File: rtl/decode_queue.sv
// Instruction queue between fetch and decode: circular buffer of {pc, instr}
// with optional empty-queue bypass, flush on clear and next-pc on the head.
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int XLEN   = DQ_XLEN,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1,
  parameter int AFULL  = DEPTH - 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       f_valid,
  input  logic [XLEN-1:0]            f_pc,
  input  logic [31:0]                f_instr,
  output logic                       f_ready,
  output logic                       d_valid,
  output logic [XLEN-1:0]            d_pc,
  output logic [31:0]                d_instr,
  output logic [XLEN-1:0]            d_npc,
  input  logic                       d_ready,
  input  logic                       clear,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full
);

  localparam int   PW  = $clog2(DEPTH);
  localparam int   CW  = $clog2(DEPTH+1);
  localparam logic BYP = (BYPASS != 0);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } entry_t;

  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  logic   is_empty, is_full;
  logic   bypass_taken, push, pop;
  entry_t head;

  // Handshake: a beat transfers on a clock edge where valid and ready are both
  // high; the sender holds valid and payload stable until that edge.
  always_comb begin
    is_empty     = (count_q == '0);
    is_full      = (count_q == CW'(DEPTH));
    f_ready      = !is_full && !clear;
    bypass_taken = BYP && is_empty && f_valid && d_ready && !clear;
    push         = f_valid && f_ready && !clear && !bypass_taken;
    pop          = !is_empty && d_ready && !clear;
  end

  always_comb begin
    head    = '{pc: '0, instr: nop_instr};
    d_valid = 1'b0;
    if (!clear) begin
      if (!is_empty) begin
        d_valid = 1'b1;
        head    = mem_q[rptr_q];
      end else if (BYP && f_valid) begin
        d_valid = 1'b1;
        head    = '{pc: f_pc, instr: f_instr};
      end
    end
    d_pc        = head.pc;
    d_instr     = head.instr;
    d_npc       = XLEN'(npc_calc(64'(head.pc), head.instr));
    count       = count_q;
    empty       = is_empty;
    full        = is_full;
    almost_full = (count_q >= CW'(AFULL));
  end

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
    if (push) begin
      mem_d[wptr_q] = '{pc: f_pc, instr: f_instr};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  // Storage is not reset; only pointers and occupancy define validity.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: directed scenarios followed by random traffic, all
// checked against a queue-based reference model of fetch/decode transfers.
module tb_decode_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 4;
  localparam int AFULL = DEPTH - 1;
  localparam int CW    = $clog2(DEPTH+1);

  logic            clock = 1'b0;
  logic            reset;
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [31:0]     f_instr;
  logic            f_ready;
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [31:0]     d_instr;
  logic [XLEN-1:0] d_npc;
  logic            d_ready;
  logic            clear;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;
  logic            almost_full;

  always #5 clock = ~clock;

  decode_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .BYPASS(1), .AFULL(AFULL)) dut (
    .clock(clock), .reset(reset),
    .f_valid(f_valid), .f_pc(f_pc), .f_instr(f_instr), .f_ready(f_ready),
    .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr), .d_npc(d_npc),
    .d_ready(d_ready), .clear(clear), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [63:0] exp_q[$];
  logic        accepted = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    int          sz;
    logic        ev;
    logic [31:0] epc, ein, enpc;
    sz  = exp_q.size();
    ev  = 1'b0;
    epc = 32'h0;
    ein = 32'h00000013;
    if (!clear) begin
      if (sz > 0) begin
        ev  = 1'b1;
        epc = exp_q[0][63:32];
        ein = exp_q[0][31:0];
      end else if (f_valid) begin
        ev  = 1'b1;
        epc = f_pc;
        ein = f_instr;
      end
    end
    enpc = epc + ((ein[1:0] == 2'b11) ? 32'd4 : 32'd2);
    chk("d_valid", 64'(d_valid), 64'(ev));
    chk("d_pc", 64'(d_pc), 64'(epc));
    chk("d_instr", 64'(d_instr), 64'(ein));
    chk("d_npc", 64'(d_npc), 64'(enpc));
    chk("count", 64'(count), 64'(sz));
    chk("empty", 64'(empty), 64'(sz == 0));
    chk("full", 64'(full), 64'(sz == DEPTH));
    chk("almost_full", 64'(almost_full), 64'(sz >= AFULL));
    chk("f_ready", 64'(f_ready), 64'((sz < DEPTH) && !clear));
  endtask

  // What happened at this edge, judged only from the transfer rules.
  task automatic model_update();
    int   sz;
    logic do_pop, do_byp, do_push;
    accepted = 1'b0;
    if (reset || clear) begin
      exp_q.delete();
    end else begin
      sz      = exp_q.size();
      do_pop  = (sz > 0) && d_ready;
      do_byp  = (sz == 0) && d_ready && f_valid;
      do_push = f_valid && (sz < DEPTH) && !do_byp;
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({f_pc, f_instr});
      accepted = do_push || do_byp;
    end
  endtask

  task automatic pre();
    #3;
    if (!reset) check_outputs();
  endtask

  task automatic post();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cycle();
    pre();
    post();
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                       input logic dr, input logic clr);
    f_valid = v;
    f_pc    = pc;
    f_instr = ins;
    d_ready = dr;
    clear   = clr;
  endtask

  logic [31:0] drain_pc [4] = '{32'h0, 32'h4, 32'h6, 32'hA};
  logic [31:0] drain_in [4] = '{32'h00100093, 32'h00004501, 32'h00200113, 32'h00300193};
  logic [31:0] pc_acc;
  logic [31:0] rnd;
  logic [15:0] rnd16;

  initial begin
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;

    // Reset state while idle.
    pre();
    chk("rst_d_instr", 64'(d_instr), 64'h00000013);
    chk("rst_d_npc", 64'(d_npc), 64'h4);
    post();

    // Empty-queue bypass.
    drive(1'b1, 32'h100, 32'h00A00513, 1'b1, 1'b0);
    pre();
    chk("byp_pc", 64'(d_pc), 64'h100);
    chk("byp_npc", 64'(d_npc), 64'h104);
    post();

    // Fill to full while decode stalls, then drain in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, drain_pc[i], drain_in[i], 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    pre();
    chk("fill_full", 64'(full), 64'h1);
    chk("fill_count", 64'(count), 64'h4);
    post();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      pre();
      chk("drain_pc", 64'(d_pc), 64'(drain_pc[i]));
      if (i == 1) chk("drain_npc_c", 64'(d_npc), 64'h6);
      post();
    end

    // Occupancy 2 with push and pop every cycle across pointer wrap.
    drive(1'b1, 32'h200, 32'h00000013, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h204, 32'h00000013, 1'b0, 1'b0);
    cycle();
    pc_acc = 32'h208;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, pc_acc, 32'h00000013, 1'b1, 1'b0);
      pre();
      chk("steady_count", 64'(count), 64'h2);
      post();
      pc_acc = pc_acc + 32'd4;
    end
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();
    cycle();

    // Clear at occupancy 3 with a beat presented; the beat then bypasses.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h300 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
      cycle();
    end
    drive(1'b1, 32'h400, 32'h00A00513, 1'b1, 1'b1);
    pre();
    chk("clr_d_valid", 64'(d_valid), 64'h0);
    post();
    drive(1'b1, 32'h400, 32'h00A00513, 1'b1, 1'b0);
    pre();
    chk("clr_count", 64'(count), 64'h0);
    chk("clr_byp_pc", 64'(d_pc), 64'h400);
    post();

    // Reset mid-operation at occupancy 3, then a fresh start.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h500 + 32'(4 * i), 32'h00000013, 1'b0, 1'b0);
      cycle();
    end
    reset = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
    pre();
    chk("rst_mid_count", 64'(count), 64'h0);
    chk("rst_mid_valid", 64'(d_valid), 64'h0);
    post();
    drive(1'b1, 32'h600, 32'h00000013, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 32'h604, 32'h00004501, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    pre();
    chk("rst_fresh_pc", 64'(d_pc), 64'h600);
    post();
    cycle();

    // Next-pc wrap at the top of the address space.
    drive(1'b1, 32'hFFFFFFFF, 32'h00000013, 1'b1, 1'b0);
    pre();
    chk("wrap_npc32", 64'(d_npc), 64'h3);
    post();
    drive(1'b1, 32'hFFFFFFFF, 32'h00004501, 1'b1, 1'b0);
    pre();
    chk("wrap_npc16", 64'(d_npc), 64'h1);
    post();
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    cycle();

    // Random traffic; fetch holds an unaccepted beat stable.
    accepted = 1'b1;
    pc_acc   = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      if (!f_valid || accepted) begin
        f_valid = ($urandom_range(0, 3) != 0);
        f_pc    = pc_acc;
        if ($urandom_range(0, 1) == 0) begin
          rnd16   = 16'($urandom);
          rnd16[1:0] = 2'($urandom_range(0, 2));
          f_instr = {16'h0, rnd16};
          if (f_valid) pc_acc = pc_acc + 32'd2;
        end else begin
          rnd     = $urandom;
          f_instr = {rnd[31:2], 2'b11};
          if (f_valid) pc_acc = pc_acc + 32'd4;
        end
      end
      d_ready = ($urandom_range(0, 9) < ((i / 50) % 2 == 0 ? 3 : 8));
      clear   = ($urandom_range(0, 29) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
